// File: rtl/ex_trap_arbiter.sv
// ex_trap_arbiter: shares the core's single external-trap handshake among
// SRC_NUM peripheral interrupt sources. Rising edges on src_req become pending
// bits, the enabled pending set is arbitrated, and the winner is presented on
// trap_valid/trap_id until the core accepts it. A programmable idle gap follows
// every acceptance.
//
// Build option: define EX_TRAP_FIXPRI_EN for fixed priority (lowest eligible
// index wins). Left undefined, arbitration is round-robin from a rotating
// pointer that moves past the last accepted source.
module ex_trap_arbiter #(
    parameter int SRC_NUM = 8,
    parameter int GAP_CYC = 4,
    parameter int ID_W    = $clog2(SRC_NUM)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SRC_NUM-1:0] src_req,
    input  logic [SRC_NUM-1:0] src_mask,
    output logic               trap_valid,
    input  logic               trap_ready,
    output logic [ID_W-1:0]    trap_id,
    output logic [SRC_NUM-1:0] src_ack,
    output logic [SRC_NUM-1:0] pend
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0]         GAP_INIT = 8'(GAP_CYC);
    localparam logic [SRC_NUM-1:0] ONE_V    = {{(SRC_NUM-1){1'b0}}, 1'b1};
    localparam logic [SRC_NUM-1:0] ZERO_V   = {SRC_NUM{1'b0}};

    // Index of the lowest set bit of v (0 when v is empty; callers gate on |v).
    function automatic logic [ID_W-1:0] first_set(input logic [SRC_NUM-1:0] v);
        logic [ID_W-1:0] idx;
        logic            found;
        idx   = {ID_W{1'b0}};
        found = 1'b0;
        for (int i = 0; i < SRC_NUM; i++) begin
            if (!found && v[i]) begin
                idx   = ID_W'(i);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return idx;
    endfunction

    state_t             state_r;
    logic [SRC_NUM-1:0] src_q_r;
    logic [SRC_NUM-1:0] pend_r;
    logic [SRC_NUM-1:0] src_ack_r;
    logic [7:0]         cnt_r;
    logic               trap_valid_r;
    logic [ID_W-1:0]    trap_id_r;

    logic [SRC_NUM-1:0] event_s;
    logic [SRC_NUM-1:0] elig_s;
    logic [SRC_NUM-1:0] grant_vec_s;
    logic [SRC_NUM-1:0] clr_s;
    logic [SRC_NUM-1:0] pend_next_s;
    logic               accept_s;
    logic [ID_W-1:0]    sel_idx_s;

    assign event_s     = src_req & ~src_q_r;
    assign elig_s      = pend_r & src_mask;
    assign accept_s    = (state_r == ST_REQ) && trap_ready;
    assign grant_vec_s = ONE_V << trap_id_r;
    // A fresh edge on the source being accepted wins over the clear.
    assign pend_next_s = (pend_r & ~clr_s) | event_s;

`ifdef EX_TRAP_FIXPRI_EN
    // Fixed priority: lowest eligible index is the candidate.
    always_comb begin
        clr_s     = accept_s ? grant_vec_s : ZERO_V;
        sel_idx_s = first_set(elig_s);
    end
`else
    logic [ID_W-1:0]    ptr_r;
    logic [SRC_NUM-1:0] rot_s;
    logic [ID_W-1:0]    off_s;
    logic [ID_W:0]      sum_s;

    // Round-robin: rotate the eligible set so ptr sits at bit 0, take the
    // first set bit, then map the offset back onto the source range.
    always_comb begin
        clr_s = accept_s ? grant_vec_s : ZERO_V;
        rot_s = SRC_NUM'({elig_s, elig_s} >> ptr_r);
        off_s = first_set(rot_s);
        sum_s = {1'b0, ptr_r} + {1'b0, off_s};
        if (sum_s >= (ID_W+1)'(SRC_NUM)) begin
            sum_s = sum_s - (ID_W+1)'(SRC_NUM);
        end else begin
            sum_s = sum_s;
        end
        sel_idx_s = sum_s[ID_W-1:0];
    end
`endif

    // Edge capture, pending bookkeeping and the IDLE/REQ/GAP handshake FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            src_q_r      <= ZERO_V;
            pend_r       <= ZERO_V;
            src_ack_r    <= ZERO_V;
            cnt_r        <= 8'd0;
            trap_valid_r <= 1'b0;
            trap_id_r    <= {ID_W{1'b0}};
`ifndef EX_TRAP_FIXPRI_EN
            ptr_r        <= {ID_W{1'b0}};
`endif
        end else begin
            src_q_r   <= src_req;
            pend_r    <= pend_next_s;
            src_ack_r <= ZERO_V;
            case (state_r)
                ST_IDLE: begin
                    if (|elig_s) begin
                        trap_id_r    <= sel_idx_s;
                        trap_valid_r <= 1'b1;
                        state_r      <= ST_REQ;
                    end else begin
                        trap_valid_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // Request is held regardless of mask changes until accepted.
                    if (trap_ready) begin
                        trap_valid_r <= 1'b0;
                        src_ack_r    <= grant_vec_s;
`ifndef EX_TRAP_FIXPRI_EN
                        ptr_r <= (trap_id_r == ID_W'(SRC_NUM-1)) ? {ID_W{1'b0}}
                                                                 : trap_id_r + ID_W'(1);
`endif
                        if (GAP_INIT == 8'd0) begin
                            state_r <= ST_IDLE;
                            cnt_r   <= 8'd0;
                        end else begin
                            state_r <= ST_GAP;
                            cnt_r   <= GAP_INIT;
                        end
                    end else begin
                        trap_valid_r <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_r <= 8'd1) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 8'd0;
                    end else begin
                        cnt_r <= cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    trap_valid_r <= 1'b0;
                    cnt_r        <= 8'd0;
                end
            endcase
        end
    end

    assign trap_valid = trap_valid_r;
    assign trap_id    = trap_id_r;
    assign src_ack    = src_ack_r;
    assign pend       = pend_r;

endmodule
